deserializer: RTL and testbench
===============================

// Module: deserializer
// PURPOSE
//   Receive end of the accelerator's LSB-first serial link. Samples serial_data on every
//   serial_clk edge where frame_sync is high and assembles WIDTH-bit words.
//   Each complete word is presented on a one-entry parallel output buffer with a
//   valid/ready handshake. Short frames and overruns are flagged.
// PARAMETERS
//   WIDTH   32   bits per frame; also the width of parallel_data
//   CNT_W   16   width of the saturating good-frame counter frame_count
// PORTS
//   serial_clk     in   1        receive clock; all state changes on its rising edge
//   rst_n          in   1        reset, asynchronous, active-low
//   serial_data    in   1        serial bit; bit k of the frame is in the k-th frame_sync-high cycle
//   frame_sync     in   1        high for exactly WIDTH consecutive cycles per frame
//   parallel_data  out  WIDTH    assembled word; held stable while data_valid=1
//   data_valid     out  1        output buffer holds an unconsumed word
//   data_ready     in   1        consumer accepts the word when data_valid & data_ready
//   busy           out  1        high while in RECV
//   frame_err      out  1        1-cycle pulse: frame_sync dropped before WIDTH bits
//   overrun        out  1        1-cycle pulse: completed word dropped because buffer full
//   frame_count    out  CNT_W    count of words loaded into the buffer; saturates at all-ones
// BEHAVIOUR
//   Reset (async assert, sync deassert internally): parallel_data=0, data_valid=0, busy=0,
//     frame_err=0, overrun=0, frame_count=0, bit counter=0, shift reg=0, state=WAIT.
//   States:
//     WAIT  armed once frame_sync is sampled low; prevents locking onto a frame already in progress
//           when reset is released. WAIT->IDLE on any edge with frame_sync=0.
//     IDLE  frame_sync=1: shift in bit 0, cnt=1, ->RECV. frame_sync=0: stay.
//     RECV  frame_sync=1: shift in bit at position cnt, cnt++.
//           - On the bit at cnt==WIDTH-1 the word is complete: ->IDLE, cnt=0.
//           frame_sync=0 with cnt<WIDTH: frame_err=1 for one cycle, partial word discarded, ->IDLE.
//   Bit order: LSB first; the first sampled bit lands in parallel_data[0].
//   Back-to-back frames: frame_sync high on the cycle after a completed word starts a new frame
//     with no idle gap. The IDLE check is made on that same edge.
//   frame_sync held high beyond WIDTH bits is treated as the next frame.
//   Output buffer (one entry):
//     - Word completes and (data_valid=0 or data_ready=1 on that edge): load parallel_data,
//       data_valid=1, frame_count++ (saturating). Latency: data_valid visible the cycle after
//       the edge that samples bit WIDTH-1.
//     - Word completes and data_valid=1 and data_ready=0: new word dropped, buffer unchanged,
//       overrun=1 for one cycle, frame_count unchanged.
//     - data_valid & data_ready with no completing word: data_valid->0. parallel_data keeps
//       its last value.
//   frame_err and overrun are never asserted on the same cycle. Both are registered, not combinational.
//   rst_n asserted mid-frame: partial word and buffer contents lost immediately. Behaviour
//     after release follows the WAIT rule.
// TESTING
//   1. WIDTH=32, one frame 0xA5A5_3C0F, data_ready=1 -> data_valid 1 cycle after 32nd bit,
//      parallel_data=0xA5A5_3C0F, frame_count=1.
//   2. Two back-to-back frames 0x0000_0001, 0x8000_0000, data_ready=1 -> two valid words
//      in order, no frame_err, frame_count=2.
//   3. frame_sync high for 12 cycles then low -> frame_err pulse 1 cycle, data_valid stays 0,
//      next full frame 0x1234_5678 received correctly.
//   4. data_ready=0, frames 0xDEAD_BEEF then 0xCAFE_F00D -> buffer holds 0xDEAD_BEEF,
//      overrun pulse at end of 2nd frame. Raise data_ready -> one handshake, then data_valid=0.
//   5. Release rst_n at frame_sync bit 10 of an active frame -> no word, no frame_err for that
//      frame. The following full frame 0x0F0F_0F0F is received.
//   6. Assert rst_n at bit 20 -> all outputs 0 immediately. frame_count saturation checked with
//      CNT_W=2: 5 frames -> frame_count=3.

Source files
------------

// File: rtl/deserializer_if.sv
// Parallel output side of the serial-link receiver: one word plus valid/ready handshake.
interface deserializer_if #(
  parameter int WIDTH = 32
);
  logic [WIDTH-1:0] parallel_data;
  logic             data_valid;
  logic             data_ready;

  modport master (output parallel_data, data_valid, input data_ready);
  modport slave  (input parallel_data, data_valid, output data_ready);
endinterface

// File: rtl/deserializer.sv
// LSB-first serial-to-parallel receiver with a one-entry output buffer,
// short-frame and overrun flags, and a saturating good-frame counter.
module deserializer #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 16
) (
  input  logic             serial_clk,
  input  logic             rst_n,
  input  logic             serial_data,
  input  logic             frame_sync,
  deserializer_if.master   par,
  output logic             busy,
  output logic             frame_err,
  output logic             overrun,
  output logic [CNT_W-1:0] frame_count
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_WAIT,
    S_IDLE,
    S_RECV
  } state_t;

  state_t           state;
  logic [CW-1:0]    bit_cnt;
  logic [WIDTH-1:0] shift_reg;
  logic [WIDTH-1:0] data_q;
  logic             valid_q;
  logic [1:0]       rst_sync;
  logic             rst_int_n;

  // Reset asserts immediately but releases only after two clean clock edges.
  always_ff @(posedge serial_clk or negedge rst_n) begin
    if (!rst_n) rst_sync <= 2'b00;
    else        rst_sync <= {rst_sync[0], 1'b1};
  end

  assign rst_int_n         = rst_sync[1];
  assign par.parallel_data = data_q;
  assign par.data_valid    = valid_q;

  // The shift register fills from the top, so after WIDTH bits the first bit sits at bit 0.
  always_ff @(posedge serial_clk or negedge rst_int_n) begin
    if (!rst_int_n) begin
      state       <= S_WAIT;
      bit_cnt     <= '0;
      shift_reg   <= '0;
      data_q      <= '0;
      valid_q     <= 1'b0;
      busy        <= 1'b0;
      frame_err   <= 1'b0;
      overrun     <= 1'b0;
      frame_count <= '0;
    end else begin
      frame_err <= 1'b0;
      overrun   <= 1'b0;
      if (valid_q && par.data_ready) valid_q <= 1'b0;

      case (state)
        S_WAIT: begin
          if (!frame_sync) state <= S_IDLE;
        end
        S_IDLE: begin
          if (frame_sync) begin
            shift_reg <= {serial_data, shift_reg[WIDTH-1:1]};
            bit_cnt   <= CW'(1);
            state     <= S_RECV;
            busy      <= 1'b1;
          end
        end
        S_RECV: begin
          if (frame_sync) begin
            shift_reg <= {serial_data, shift_reg[WIDTH-1:1]};
            if (bit_cnt == LAST_BIT) begin
              bit_cnt <= '0;
              state   <= S_IDLE;
              busy    <= 1'b0;
              // A consumer accepting on this edge frees the slot for the new word.
              if (!valid_q || par.data_ready) begin
                data_q  <= {serial_data, shift_reg[WIDTH-1:1]};
                valid_q <= 1'b1;
                if (frame_count != {CNT_W{1'b1}}) frame_count <= frame_count + 1'b1;
              end else begin
                overrun <= 1'b1;
              end
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end else begin
            frame_err <= 1'b1;
            bit_cnt   <= '0;
            state     <= S_IDLE;
            busy      <= 1'b0;
          end
        end
        default: state <= S_WAIT;
      endcase
    end
  end

endmodule

// File: tb/tb_deserializer.sv
// Scenario-driven bench for deserializer; a second instance with a 2-bit counter
// shares the same serial stream to exercise counter saturation.
module tb_deserializer;

  localparam int WIDTH = 32;

  logic              serial_clk;
  logic              rst_n;
  logic              serial_data;
  logic              frame_sync;
  logic              data_ready;
  logic              busy, frame_err, overrun;
  logic [15:0]       frame_count;
  logic              busy2, frame_err2, overrun2;
  logic [1:0]        frame_count2;

  int total  = 0;
  int passed = 0;

  deserializer_if #(.WIDTH(WIDTH)) par_if ();
  deserializer_if #(.WIDTH(WIDTH)) par_if2 ();

  assign par_if.data_ready  = data_ready;
  assign par_if2.data_ready = data_ready;

  deserializer #(.WIDTH(WIDTH), .CNT_W(16)) dut (
    .serial_clk  (serial_clk),
    .rst_n       (rst_n),
    .serial_data (serial_data),
    .frame_sync  (frame_sync),
    .par         (par_if),
    .busy        (busy),
    .frame_err   (frame_err),
    .overrun     (overrun),
    .frame_count (frame_count)
  );

  deserializer #(.WIDTH(WIDTH), .CNT_W(2)) dut_sat (
    .serial_clk  (serial_clk),
    .rst_n       (rst_n),
    .serial_data (serial_data),
    .frame_sync  (frame_sync),
    .par         (par_if2),
    .busy        (busy2),
    .frame_err   (frame_err2),
    .overrun     (overrun2),
    .frame_count (frame_count2)
  );

  initial serial_clk = 1'b0;
  always #5 serial_clk = ~serial_clk;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  // Inputs change on the falling edge; outputs are sampled 2 time units after the rising edge.
  task automatic drive_cycle(input logic fs, input logic sd, input logic rdy);
    @(negedge serial_clk);
    frame_sync  = fs;
    serial_data = sd;
    data_ready  = rdy;
  endtask

  task automatic send_bits(input logic [WIDTH-1:0] word, input int nbits, input logic rdy);
    for (int k = 0; k < nbits; k++) drive_cycle(1'b1, word[k], rdy);
  endtask

  task automatic apply_reset();
    @(negedge serial_clk);
    rst_n = 1'b0; frame_sync = 1'b0; serial_data = 1'b0; data_ready = 1'b1;
    repeat (3) @(negedge serial_clk);
    rst_n = 1'b1;
    repeat (4) drive_cycle(1'b0, 1'b0, 1'b1);
  endtask

  task automatic test_reset();
    @(negedge serial_clk);
    rst_n = 1'b0; frame_sync = 1'b0; serial_data = 1'b0; data_ready = 1'b0;
    repeat (2) @(negedge serial_clk);
    total++;
    if ({par_if.data_valid, busy, frame_err, overrun} !== 4'b0000)
      $display("[TB] FAIL reset_flags: got %b expected 0000", {par_if.data_valid, busy, frame_err, overrun});
    else passed++;
    total++;
    if (par_if.parallel_data !== '0 || frame_count !== 16'd0 || frame_count2 !== 2'd0)
      $display("[TB] FAIL reset_data: got data=%h cnt=%0d cnt2=%0d expected 0", par_if.parallel_data, frame_count, frame_count2);
    else passed++;
    rst_n = 1'b1;
    repeat (4) drive_cycle(1'b0, 1'b0, 1'b1);
  endtask

  task automatic test_single_frame();
    apply_reset();
    send_bits(32'hA5A5_3C0F, WIDTH - 1, 1'b1);
    @(posedge serial_clk); #2;
    total++;
    if ({busy, par_if.data_valid} !== 2'b10)
      $display("[TB] FAIL single_before_last: got busy,valid=%b expected 10", {busy, par_if.data_valid});
    else passed++;
    drive_cycle(1'b1, 1'b1, 1'b1);
    @(posedge serial_clk); #2;
    total++;
    if (par_if.data_valid !== 1'b1 || par_if.parallel_data !== 32'hA5A5_3C0F || busy !== 1'b0)
      $display("[TB] FAIL single_word: got valid=%b data=%h busy=%b expected 1 a5a53c0f 0", par_if.data_valid, par_if.parallel_data, busy);
    else passed++;
    total++;
    if (frame_count !== 16'd1)
      $display("[TB] FAIL single_count: got %0d expected 1", frame_count);
    else passed++;
    drive_cycle(1'b0, 1'b0, 1'b1);
    @(posedge serial_clk); #2;
    total++;
    if (par_if.data_valid !== 1'b0 || par_if.parallel_data !== 32'hA5A5_3C0F)
      $display("[TB] FAIL single_consumed: got valid=%b data=%h expected 0 a5a53c0f", par_if.data_valid, par_if.parallel_data);
    else passed++;
  endtask

  task automatic test_back_to_back();
    apply_reset();
    send_bits(32'h0000_0001, WIDTH, 1'b1);
    @(posedge serial_clk); #2;
    total++;
    if (par_if.data_valid !== 1'b1 || par_if.parallel_data !== 32'h0000_0001 || frame_err !== 1'b0)
      $display("[TB] FAIL b2b_first: got valid=%b data=%h err=%b expected 1 00000001 0", par_if.data_valid, par_if.parallel_data, frame_err);
    else passed++;
    send_bits(32'h8000_0000, WIDTH, 1'b1);
    @(posedge serial_clk); #2;
    total++;
    if (par_if.data_valid !== 1'b1 || par_if.parallel_data !== 32'h8000_0000 || frame_err !== 1'b0)
      $display("[TB] FAIL b2b_second: got valid=%b data=%h err=%b expected 1 80000000 0", par_if.data_valid, par_if.parallel_data, frame_err);
    else passed++;
    total++;
    if (frame_count !== 16'd2)
      $display("[TB] FAIL b2b_count: got %0d expected 2", frame_count);
    else passed++;
    drive_cycle(1'b0, 1'b0, 1'b1);
  endtask

  task automatic test_short_frame();
    apply_reset();
    send_bits($urandom, 12, 1'b1);
    drive_cycle(1'b0, 1'b0, 1'b1);
    @(posedge serial_clk); #2;
    total++;
    if (frame_err !== 1'b1 || par_if.data_valid !== 1'b0)
      $display("[TB] FAIL short_err: got err=%b valid=%b expected 1 0", frame_err, par_if.data_valid);
    else passed++;
    drive_cycle(1'b0, 1'b0, 1'b1);
    @(posedge serial_clk); #2;
    total++;
    if (frame_err !== 1'b0 || par_if.data_valid !== 1'b0)
      $display("[TB] FAIL short_pulse_len: got err=%b valid=%b expected 0 0", frame_err, par_if.data_valid);
    else passed++;
    send_bits(32'h1234_5678, WIDTH, 1'b1);
    @(posedge serial_clk); #2;
    total++;
    if (par_if.data_valid !== 1'b1 || par_if.parallel_data !== 32'h1234_5678 || frame_count !== 16'd1)
      $display("[TB] FAIL short_recover: got valid=%b data=%h cnt=%0d expected 1 12345678 1", par_if.data_valid, par_if.parallel_data, frame_count);
    else passed++;
    drive_cycle(1'b0, 1'b0, 1'b1);
  endtask

  task automatic test_overrun();
    apply_reset();
    send_bits(32'hDEAD_BEEF, WIDTH, 1'b0);
    @(posedge serial_clk); #2;
    total++;
    if (par_if.data_valid !== 1'b1 || par_if.parallel_data !== 32'hDEAD_BEEF || overrun !== 1'b0)
      $display("[TB] FAIL ovr_first: got valid=%b data=%h ovr=%b expected 1 deadbeef 0", par_if.data_valid, par_if.parallel_data, overrun);
    else passed++;
    send_bits(32'hCAFE_F00D, WIDTH, 1'b0);
    @(posedge serial_clk); #2;
    total++;
    if (overrun !== 1'b1 || frame_err !== 1'b0 || par_if.parallel_data !== 32'hDEAD_BEEF || frame_count !== 16'd1)
      $display("[TB] FAIL ovr_pulse: got ovr=%b err=%b data=%h cnt=%0d expected 1 0 deadbeef 1", overrun, frame_err, par_if.parallel_data, frame_count);
    else passed++;
    drive_cycle(1'b0, 1'b0, 1'b0);
    @(posedge serial_clk); #2;
    total++;
    if (overrun !== 1'b0 || par_if.data_valid !== 1'b1)
      $display("[TB] FAIL ovr_hold: got ovr=%b valid=%b expected 0 1", overrun, par_if.data_valid);
    else passed++;
    drive_cycle(1'b0, 1'b0, 1'b1);
    @(posedge serial_clk); #2;
    total++;
    if (par_if.data_valid !== 1'b0 || par_if.parallel_data !== 32'hDEAD_BEEF)
      $display("[TB] FAIL ovr_drain: got valid=%b data=%h expected 0 deadbeef", par_if.data_valid, par_if.parallel_data);
    else passed++;
  endtask

  task automatic test_release_mid_frame();
    logic [WIDTH-1:0] junk;
    int               seen;
    junk = $urandom;
    seen = 0;
    @(negedge serial_clk);
    rst_n = 1'b0; frame_sync = 1'b0; data_ready = 1'b1;
    repeat (2) @(negedge serial_clk);
    for (int k = 0; k < WIDTH; k++) begin
      drive_cycle(1'b1, junk[k], 1'b1);
      if (k == 10) rst_n = 1'b1;
      @(posedge serial_clk); #2;
      if (par_if.data_valid || frame_err || busy) seen++;
    end
    for (int g = 0; g < 3; g++) begin
      drive_cycle(1'b0, 1'b0, 1'b1);
      @(posedge serial_clk); #2;
      if (par_if.data_valid || frame_err || busy) seen++;
    end
    total++;
    if (seen !== 0 || frame_count !== 16'd0)
      $display("[TB] FAIL release_ignored: got activity=%0d cnt=%0d expected 0 0", seen, frame_count);
    else passed++;
    send_bits(32'h0F0F_0F0F, WIDTH, 1'b1);
    @(posedge serial_clk); #2;
    total++;
    if (par_if.data_valid !== 1'b1 || par_if.parallel_data !== 32'h0F0F_0F0F || frame_count !== 16'd1)
      $display("[TB] FAIL release_next: got valid=%b data=%h cnt=%0d expected 1 0f0f0f0f 1", par_if.data_valid, par_if.parallel_data, frame_count);
    else passed++;
    drive_cycle(1'b0, 1'b0, 1'b1);
  endtask

  task automatic test_assert_mid_frame();
    apply_reset();
    send_bits($urandom, WIDTH, 1'b0);
    send_bits($urandom, 20, 1'b0);
    @(posedge serial_clk); #2;
    rst_n = 1'b0;
    #1;
    total++;
    if ({par_if.data_valid, busy, frame_err, overrun} !== 4'b0000 || par_if.parallel_data !== '0 || frame_count !== 16'd0)
      $display("[TB] FAIL assert_clear: got flags=%b data=%h cnt=%0d expected 0 0 0",
               {par_if.data_valid, busy, frame_err, overrun}, par_if.parallel_data, frame_count);
    else passed++;
    @(negedge serial_clk);
    frame_sync = 1'b0;
    rst_n = 1'b1;
    repeat (4) drive_cycle(1'b0, 1'b0, 1'b1);
  endtask

  task automatic test_saturation();
    apply_reset();
    for (int f = 0; f < 5; f++) send_bits($urandom, WIDTH, 1'b1);
    @(posedge serial_clk); #2;
    total++;
    if (frame_count2 !== 2'd3)
      $display("[TB] FAIL sat_cnt2: got %0d expected 3", frame_count2);
    else passed++;
    total++;
    if (frame_count !== 16'd5)
      $display("[TB] FAIL sat_cnt16: got %0d expected 5", frame_count);
    else passed++;
    drive_cycle(1'b0, 1'b0, 1'b1);
  endtask

  // Reference: per edge, the bench knows whether a frame ends or breaks; buffer rules give the rest.
  task automatic test_random();
    logic [WIDTH-1:0] word, md;
    logic             mv, fs, sd, rdy, comp, exp_err, exp_ovr;
    int               len, gap, loads;
    bit               is_short;
    apply_reset();
    mv = 1'b0; md = '0; loads = 0;
    for (int f = 0; f < 40; f++) begin
      word     = $urandom;
      is_short = ($urandom_range(0, 5) == 0);
      len      = is_short ? int'($urandom_range(1, WIDTH - 1)) : WIDTH;
      gap      = is_short ? int'($urandom_range(1, 2)) : int'($urandom_range(0, 2));
      for (int t = 0; t < len + gap; t++) begin
        fs  = (t < len);
        sd  = fs ? word[t] : 1'b0;
        rdy = 1'($urandom_range(0, 1));
        drive_cycle(fs, sd, rdy);
        @(posedge serial_clk); #2;
        comp    = fs && (t == WIDTH - 1);
        exp_err = is_short && (t == len);
        exp_ovr = 1'b0;
        if (comp) begin
          if (!mv || rdy) begin mv = 1'b1; md = word; loads++; end
          else exp_ovr = 1'b1;
        end else if (mv && rdy) begin
          mv = 1'b0;
        end
        total++;
        if ({par_if.data_valid, overrun, frame_err} !== {mv, exp_ovr, exp_err})
          $display("[TB] FAIL rand_flags f=%0d t=%0d: got valid,ovr,err=%b expected %b",
                   f, t, {par_if.data_valid, overrun, frame_err}, {mv, exp_ovr, exp_err});
        else passed++;
        if (mv) begin
          total++;
          if (par_if.parallel_data !== md)
            $display("[TB] FAIL rand_data f=%0d t=%0d: got %h expected %h", f, t, par_if.parallel_data, md);
          else passed++;
        end
      end
    end
    total++;
    if (frame_count !== 16'(loads) || frame_count2 !== 2'((loads > 3) ? 3 : loads))
      $display("[TB] FAIL rand_count: got %0d/%0d expected %0d/%0d",
               frame_count, frame_count2, loads, (loads > 3) ? 3 : loads);
    else passed++;
  endtask

  initial begin
    rst_n = 1'b0; frame_sync = 1'b0; serial_data = 1'b0; data_ready = 1'b0;
    test_reset();
    test_single_frame();
    test_back_to_back();
    test_short_frame();
    test_overrun();
    test_release_mid_frame();
    test_assert_mid_frame();
    test_saturation();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
